// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding, default widths and saturating duty step for the PWM ramp controller
package pwm_pkg;
  localparam int DUTY_W = 8;
  localparam int TICK_W = 32;
  localparam int CALC_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT_TICK, WAIT_EDGE, DONE} state_t;
  // Moves cur toward tgt by stp; the distance compare makes overshoot and wrap impossible
  function automatic logic [CALC_W-1:0] sat_step(
    input logic [CALC_W-1:0] cur,
    input logic [CALC_W-1:0] stp,
    input logic [CALC_W-1:0] tgt,
    input logic              up
  );
    return up ? ((stp >= tgt - cur) ? tgt : cur + stp)
              : ((stp >= cur - tgt) ? tgt : cur - stp);
  endfunction
endpackage

// File: rtl/pwm_ramp_ctrl_cnt.sv
// pwm_ramp_ctrl_cnt: generic up counter with synchronous load-to-zero and enable
module pwm_ramp_ctrl_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else q <= load ? '0 : en ? q + W'(1) : q;
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps PWM duty toward a target in saturating steps applied only at period boundaries
module pwm_ramp_ctrl #(
  parameter int DUTY_W = pwm_pkg::DUTY_W,
  parameter int TICK_W = pwm_pkg::TICK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] target,
  input  logic [DUTY_W-1:0] step,
  input  logic [TICK_W-1:0] tick_div,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);
  import pwm_pkg::*;
  state_t            state;
  logic [DUTY_W-1:0] cap_target, cap_step, next_duty;
  logic [TICK_W-1:0] cap_div, cnt;
  logic              up, cnt_hit, cnt_load, cnt_en;
  always_comb begin
    cnt_en    = state == WAIT_TICK;
    cnt_hit   = cnt_en && cnt == cap_div;
    cnt_load  = !cnt_en || cnt_hit;
    next_duty = DUTY_W'(sat_step(CALC_W'(duty_out), CALC_W'(cap_step), CALC_W'(cap_target), up));
  end
  pwm_ramp_ctrl_cnt #(.W(TICK_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .en  (cnt_en),
    .q   (cnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      duty_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cap_target <= '0;
      cap_step   <= '0;
      cap_div    <= '0;
      up         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start && !abort) begin
            cap_target <= target;
            cap_step   <= (step == '0) ? DUTY_W'(1) : step;
            cap_div    <= tick_div;
            up         <= target > duty_out;
            if (target == duty_out) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_TICK;
              busy  <= 1'b1;
            end
          end
        WAIT_TICK:
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt_hit) state <= WAIT_EDGE;
        WAIT_EDGE:
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (period_end) begin
            duty_out <= next_duty;
            if (next_duty == cap_target) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else state <= WAIT_TICK;
          end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
